// File: rtl/line_buffer_ctrl.sv
// Line-buffer sequencer: pre-fills the K-1 shift-RAM rows, then streams one new row
// per pass and flags the beats that complete a KxK window column.
module line_buffer_ctrl #(
  parameter int KERNEL_SIZE = 5,
  parameter int MAX_WIDTH   = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] cfg_kernel_size,
  input  logic [7:0] cfg_width,
  input  logic [7:0] cfg_height,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       lb_enable,
  output logic       lb_mode,
  output logic [2:0] lb_kernel_size,
  output logic [7:0] lb_depth,
  output logic       win_valid,
  output logic [7:0] row_cnt,
  output logic [7:0] col_cnt,
  output logic       busy,
  output logic       done,
  output logic       cfg_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_LINE, ST_DONE} state_t;

  typedef struct packed {
    logic [2:0] k;
    logic [7:0] w_m1;
    logic [7:0] h_m1;
  } cfg_t;

  state_t     state;
  cfg_t       cfg;
  logic [7:0] k8_in;
  logic [7:0] k_m1;
  logic       cfg_legal;
  logic       col_last;
  logic       row_last;

  assign k8_in     = {5'd0, cfg_kernel_size};
  assign cfg_legal = (cfg_kernel_size == 3'd3 || cfg_kernel_size == 3'd5) &&
                     (int'(cfg_kernel_size) <= KERNEL_SIZE) &&
                     (int'(cfg_width) < MAX_WIDTH) &&
                     (cfg_width >= k8_in) && (cfg_height >= k8_in) &&
                     (cfg_width >= 8'd2);

  assign k_m1     = {5'd0, cfg.k} - 8'd1;
  assign col_last = (col_cnt == cfg.w_m1);
  assign row_last = (row_cnt == cfg.h_m1);

  // Buffer output for the current beat is valid this cycle, so these stay combinational.
  assign lb_enable = in_valid & in_ready;
  assign win_valid = lb_enable && (state == ST_LINE) && (col_cnt >= k_m1);

  assign lb_kernel_size = cfg.k;
  assign lb_depth       = cfg.w_m1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cfg      <= '0;
      row_cnt  <= '0;
      col_cnt  <= '0;
      in_ready <= 1'b0;
      lb_mode  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_legal) begin
              cfg.k    <= cfg_kernel_size;
              cfg.w_m1 <= cfg_width - 8'd1;
              cfg.h_m1 <= cfg_height - 8'd1;
              row_cnt  <= '0;
              col_cnt  <= '0;
              lb_mode  <= 1'b0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              state    <= ST_FILL;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          // One pass loads rows 0..K-2 in parallel, so the next live row is K-1.
          if (lb_enable) begin
            if (col_last) begin
              col_cnt <= '0;
              row_cnt <= k_m1;
              lb_mode <= 1'b1;
              state   <= ST_LINE;
            end else begin
              col_cnt <= col_cnt + 8'd1;
            end
          end
        end
        ST_LINE: begin
          if (lb_enable) begin
            if (col_last) begin
              col_cnt <= '0;
              if (row_last) begin
                in_ready <= 1'b0;
                done     <= 1'b1;
                state    <= ST_DONE;
              end else begin
                row_cnt <= row_cnt + 8'd1;
              end
            end else begin
              col_cnt <= col_cnt + 8'd1;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl: frame counts, latencies, illegal starts, reset abort.
module tb_line_buffer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] cfg_kernel_size;
  logic [7:0] cfg_width;
  logic [7:0] cfg_height;
  logic       in_valid;
  logic       in_ready;
  logic       lb_enable;
  logic       lb_mode;
  logic [2:0] lb_kernel_size;
  logic [7:0] lb_depth;
  logic       win_valid;
  logic [7:0] row_cnt;
  logic [7:0] col_cnt;
  logic       busy;
  logic       done;
  logic       cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  line_buffer_ctrl #(.KERNEL_SIZE(5), .MAX_WIDTH(256)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_kernel_size(cfg_kernel_size), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .in_valid(in_valid), .in_ready(in_ready), .lb_enable(lb_enable), .lb_mode(lb_mode),
    .lb_kernel_size(lb_kernel_size), .lb_depth(lb_depth), .win_valid(win_valid),
    .row_cnt(row_cnt), .col_cnt(col_cnt), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic issue_start(input int k, input int w, input int h);
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b0;
    cfg_kernel_size = 3'(k); cfg_width = 8'(w); cfg_height = 8'(h);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_rdy"},  int'(in_ready), 0);
    chk({tag, "_en"},   int'(lb_enable), 0);
    chk({tag, "_mode"}, int'(lb_mode), 0);
    chk({tag, "_win"},  int'(win_valid), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"},  int'(cfg_err), 0);
    chk({tag, "_row"},  int'(row_cnt), 0);
    chk({tag, "_col"},  int'(col_cnt), 0);
    chk({tag, "_dep"},  int'(lb_depth), 0);
    chk({tag, "_k"},    int'(lb_kernel_size), 0);
  endtask

  // Runs one accepted frame cycle by cycle; a small spec-level model tracks the
  // expected counters/window flags and tallies disagreements into errs.
  task automatic run_frame(input int k, input int w, input int h, input bit toggle,
                           input bit inject, input bit abort,
                           output int fills, output int lines, output int wins,
                           output int dones, output int done_cyc, output int errs);
    int e_st, e_row, e_col, cyc;
    bit beat;
    fills = 0; lines = 0; wins = 0; dones = 0; done_cyc = -1; errs = 0;
    e_st = 0; e_row = 0; e_col = 0; cyc = 1;
    issue_start(k, w, h);
    while (1) begin
      in_valid = toggle ? (cyc % 2 == 1) : 1'b1;
      start = inject && e_st == 1 && e_row == k && e_col == 2;
      if (start) begin
        cfg_kernel_size = 3'd3; cfg_width = 8'd6; cfg_height = 8'd6;
      end
      @(negedge clk);
      if (abort && e_st == 1 && e_row == 6 && e_col == 3) return;
      if (e_st == 3) begin
        if (busy !== 1'b0) errs++;
        break;
      end
      if (e_st == 2) begin
        if (done !== 1'b1 || busy !== 1'b1) errs++;
        chk("done_rdy", int'(in_ready), 0);
      end
      if (done) begin dones++; done_cyc = cyc; end
      beat = in_valid && e_st < 2;
      if (lb_enable !== beat) errs++;
      if (e_st < 2 && (lb_mode !== (e_st == 1) || busy !== 1'b1)) errs++;
      if (int'(row_cnt) != e_row || int'(col_cnt) != e_col) errs++;
      if (win_valid !== (beat && e_st == 1 && e_col >= k - 1)) errs++;
      if (lb_enable && !lb_mode) fills++;
      if (lb_enable && lb_mode) lines++;
      if (win_valid) wins++;
      if (e_st == 2) e_st = 3;
      else if (beat) begin
        if (e_col == w - 1) begin
          e_col = 0;
          if (e_st == 0) begin e_row = k - 1; e_st = 1; end
          else if (e_row == h - 1) e_st = 2;
          else e_row++;
        end else e_col++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (cyc > 2000) begin
        chk("timeout", cyc, 0);
        break;
      end
    end
  endtask

  int f, l, wv, d, dc, e;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    cfg_kernel_size = 3'd0; cfg_width = 8'd0; cfg_height = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    #2 rst = 1'b0;

    // Abort mid-LINE at row 6 col 3, asynchronously reset, then a clean frame.
    run_frame(3, 8, 8, 0, 0, 1, f, l, wv, d, dc, e);
    chk("abort_errs", e, 0);
    chk("abort_row", int'(row_cnt), 6);
    rst = 1'b1; #1;
    check_zero("arst");
    #2 rst = 1'b0;
    run_frame(3, 8, 8, 0, 0, 0, f, l, wv, d, dc, e);
    chk("k3w8_fill", f, 8);
    chk("k3w8_line", l, 48);
    chk("k3w8_win", wv, 36);
    chk("k3w8_dcyc", dc, 57);
    chk("k3w8_errs", e, 0);

    run_frame(5, 8, 8, 0, 0, 0, f, l, wv, d, dc, e);
    chk("k5w8_fill", f, 8);
    chk("k5w8_line", l, 32);
    chk("k5w8_win", wv, 16);
    chk("k5w8_done", d, 1);
    chk("k5w8_dcyc", dc, 41);
    chk("k5w8_dep", int'(lb_depth), 7);
    chk("k5w8_k", int'(lb_kernel_size), 5);
    chk("k5w8_errs", e, 0);

    // Illegal starts: (4,8,8) (5,4,8) (5,8,3).
    for (int i = 0; i < 3; i++) begin
      issue_start(i == 0 ? 4 : 5, i == 1 ? 4 : 8, i == 2 ? 3 : 8);
      @(negedge clk);
      chk("ill_err", int'(cfg_err), 1);
      chk("ill_busy", int'(busy), 0);
      chk("ill_dep", int'(lb_depth), 7);
      @(negedge clk);
      chk("ill_err_clr", int'(cfg_err), 0);
      chk("ill_rdy", int'(in_ready), 0);
    end

    run_frame(3, 6, 4, 1, 0, 0, f, l, wv, d, dc, e);
    chk("tog_fill", f, 6);
    chk("tog_line", l, 12);
    chk("tog_win", wv, 8);
    chk("tog_done", d, 1);
    chk("tog_errs", e, 0);
    chk("tog_dep", int'(lb_depth), 5);

    run_frame(5, 8, 8, 0, 1, 0, f, l, wv, d, dc, e);
    chk("inj_line", l, 32);
    chk("inj_win", wv, 16);
    chk("inj_dcyc", dc, 41);
    chk("inj_dep", int'(lb_depth), 7);
    chk("inj_k", int'(lb_kernel_size), 5);
    chk("inj_err", int'(cfg_err), 0);
    chk("inj_errs", e, 0);

    run_frame(5, 5, 5, 0, 0, 0, f, l, wv, d, dc, e);
    chk("min_fill", f, 5);
    chk("min_line", l, 5);
    chk("min_win", wv, 1);
    chk("min_dcyc", dc, 11);
    chk("min_errs", e, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
